// File: rtl/btn_cond_pkg.sv
// Shared constants and types for the push-button conditioner.
package btn_cond_pkg;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 64;
    localparam int DEF_REPEAT_PERIOD   = 16;
    localparam int RST_STRETCH         = 2;
    localparam int DB_CNT_W            = 8;
    localparam int RPT_CNT_W           = 10;
    localparam int RST_CNT_W           = 2;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_PERIOD = 2'd2
    } rpt_state_t;
endpackage

// File: rtl/btn_debounce.sv
// One raw input: 2-flop synchronizer followed by a consecutive-cycle debounce counter.
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    logic                sync1_q, sync2_q;
    logic                db_q, db_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; the last one flips the state
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer and debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = db_q;
endmodule

// File: rtl/btn_conditioner.sv
// Turns four bouncing buttons into En/Mode/Step/Rst for a counter stage.
// Auto-repeat of held Up/Down is compiled in with BTN_COND_AUTO_REPEAT_EN.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_COND_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_step,
    input  logic btn_clr,
    output logic en,
    output logic mode,
    output logic step,
    output logic rst
);
    logic up_lvl_s, dn_lvl_s, step_lvl_s, clr_lvl_s;
    logic up_p_s, dn_p_s, clr_p_s, acc_up_s, acc_dn_s, rpt_fire_s;
    logic up_prev_q, dn_prev_q, clr_prev_q;
    logic en_q, en_d, mode_q, mode_d, step_q, step_d, rst_q, rst_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up   (.clk(clk), .rst_n(rst_n), .raw(btn_up),   .level(up_lvl_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (.clk(clk), .rst_n(rst_n), .raw(btn_down), .level(dn_lvl_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (.clk(clk), .rst_n(rst_n), .raw(btn_step), .level(step_lvl_s));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr  (.clk(clk), .rst_n(rst_n), .raw(btn_clr),  .level(clr_lvl_s));

    // Press detection, press acceptance, clear stretching and output next-state
    always_comb begin
        up_p_s    = up_lvl_s & ~up_prev_q;
        dn_p_s    = dn_lvl_s & ~dn_prev_q;
        clr_p_s   = clr_lvl_s & ~clr_prev_q;
        // A press is lost if the other direction, a clear, or an active Rst coincides
        acc_up_s  = up_p_s & ~dn_p_s & ~clr_p_s & ~rst_q;
        acc_dn_s  = dn_p_s & ~up_p_s & ~clr_p_s & ~rst_q;
        rst_d     = rst_q;
        rst_cnt_d = rst_cnt_q;
        if (clr_p_s) begin
            rst_d     = 1'b1;
            rst_cnt_d = '0;
        end else if (rst_q) begin
            if (rst_cnt_q == RST_CNT_W'(RST_STRETCH - 1)) begin
                rst_d     = 1'b0;
                rst_cnt_d = '0;
            end else begin
                rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
            end
        end else begin
            rst_cnt_d = '0;
        end
        if (acc_up_s) begin
            mode_d = 1'b1;
        end else if (acc_dn_s) begin
            mode_d = 1'b0;
        end else begin
            mode_d = mode_q;
        end
        en_d   = acc_up_s | acc_dn_s | rpt_fire_s;
        step_d = step_lvl_s;
    end

`ifdef BTN_COND_AUTO_REPEAT_EN
    rpt_state_t           rpt_state_q, rpt_state_d;
    logic [RPT_CNT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_last_s;
    logic                 rpt_hold_s;

    // Repeat runs only while the accepted button alone stays held and no clear is active
    always_comb begin
        rpt_hold_s  = (mode_q ? (up_lvl_s & ~dn_lvl_s) : (dn_lvl_s & ~up_lvl_s)) & ~rst_q & ~clr_p_s;
        rpt_last_s  = (rpt_state_q == RPT_DELAY) ? RPT_CNT_W'(REPEAT_DELAY - 1)
                                                 : RPT_CNT_W'(REPEAT_PERIOD - 1);
        rpt_fire_s  = 1'b0;
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        if (acc_up_s | acc_dn_s) begin
            rpt_state_d = RPT_DELAY;
            rpt_cnt_d   = '0;
        end else if ((rpt_state_q == RPT_IDLE) || !rpt_hold_s) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
        end else if (rpt_cnt_q == rpt_last_s) begin
            rpt_fire_s  = 1'b1;
            rpt_state_d = RPT_PERIOD;
            rpt_cnt_d   = '0;
        end else begin
            rpt_cnt_d   = rpt_cnt_q + RPT_CNT_W'(1);
        end
    end

    // Repeat state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    assign rpt_fire_s = 1'b0;
`endif

    // Edge-detect history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_prev_q  <= 1'b0;
            dn_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            en_q       <= 1'b0;
            mode_q     <= 1'b1;
            step_q     <= 1'b0;
            rst_q      <= 1'b1;
            rst_cnt_q  <= '0;
        end else begin
            up_prev_q  <= up_lvl_s;
            dn_prev_q  <= dn_lvl_s;
            clr_prev_q <= clr_lvl_s;
            en_q       <= en_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            rst_q      <= rst_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    assign en   = en_q;
    assign mode = mode_q;
    assign step = step_q;
    assign rst  = rst_q;
endmodule
